// File: rtl/vec_alu_stream.sv
// Streaming fixed-point vector ALU: LANES signed Q(WIDTH-FRAC).FRAC lanes per beat,
// add/sub/mul per beat or mac reduction of a whole burst into one accumulated beat.
module vec_alu_stream #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 4,
    parameter int LEN_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [LEN_W-1:0]         burst_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*LANES-1:0]   a_in,
    input  logic [WIDTH*LANES-1:0]   b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*LANES-1:0]   out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_MUL = 2'b10;
    localparam logic [1:0] M_MAC = 2'b11;

    localparam logic signed [WIDTH-1:0]   SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] RND     = {{(2*WIDTH-1){1'b0}}, 1'b1} << (FRAC-1);

    logic [1:0]             r_state;
    logic [1:0]             r_mode;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_cnt;
    logic [WIDTH*LANES-1:0] r_acc;
    logic [WIDTH*LANES-1:0] r_out_data;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_busy;
    logic                   r_done;

    logic [WIDTH*LANES-1:0] w_res_bus;
    logic [WIDTH*LANES-1:0] w_mac_bus;
    logic                   w_accept;
    logic                   w_out_hs;
    logic                   w_final;

    assign in_ready  = (r_state == S_RUN) && (r_cnt < r_len) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_out_hs  = r_out_valid && out_ready;
    assign w_final   = (r_cnt == r_len - 1'b1);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [WIDTH-1:0]   w_a, w_b, w_acc, w_mul, w_res;
            logic signed [WIDTH-1:0]   w_sum_sat, w_dif_sat, w_mac_sat;
            logic signed [WIDTH:0]     w_sum, w_dif, w_acc_sum;
            logic signed [2*WIDTH-1:0] w_ax, w_bx, w_prod, w_shift;

            assign w_a   = a_in[WIDTH*gi +: WIDTH];
            assign w_b   = b_in[WIDTH*gi +: WIDTH];
            assign w_acc = r_acc[WIDTH*gi +: WIDTH];

            assign w_sum     = {w_a[WIDTH-1], w_a} + {w_b[WIDTH-1], w_b};
            assign w_dif     = {w_a[WIDTH-1], w_a} - {w_b[WIDTH-1], w_b};
            assign w_sum_sat = (w_sum[WIDTH] == w_sum[WIDTH-1]) ? w_sum[WIDTH-1:0]
                             : (w_sum[WIDTH] ? SAT_MIN : SAT_MAX);
            assign w_dif_sat = (w_dif[WIDTH] == w_dif[WIDTH-1]) ? w_dif[WIDTH-1:0]
                             : (w_dif[WIDTH] ? SAT_MIN : SAT_MAX);

            // Round half up, then the result fits only if the top WIDTH+1 bits are all sign.
            assign w_ax    = {{WIDTH{w_a[WIDTH-1]}}, w_a};
            assign w_bx    = {{WIDTH{w_b[WIDTH-1]}}, w_b};
            assign w_prod  = w_ax * w_bx;
            assign w_shift = (w_prod + RND) >>> FRAC;
            assign w_mul   = (w_shift[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){w_shift[2*WIDTH-1]}})
                           ? w_shift[WIDTH-1:0]
                           : (w_shift[2*WIDTH-1] ? SAT_MIN : SAT_MAX);

            assign w_acc_sum = {w_acc[WIDTH-1], w_acc} + {w_mul[WIDTH-1], w_mul};
            assign w_mac_sat = (w_acc_sum[WIDTH] == w_acc_sum[WIDTH-1]) ? w_acc_sum[WIDTH-1:0]
                             : (w_acc_sum[WIDTH] ? SAT_MIN : SAT_MAX);

            always_comb begin
                w_res = w_mul;
                case (r_mode)
                    M_ADD:        w_res = w_sum_sat;
                    M_SUB:        w_res = w_dif_sat;
                    M_MUL, M_MAC: w_res = w_mul;
                    default:      w_res = w_mul;
                endcase
            end

            assign w_res_bus[WIDTH*gi +: WIDTH] = w_res;
            assign w_mac_bus[WIDTH*gi +: WIDTH] = w_mac_sat;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= M_ADD;
            r_len       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (burst_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_mode  <= mode;
                            r_len   <= burst_len;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        // mac only emits the accumulated lanes once, on the closing beat
                        if (r_mode == M_MAC) begin
                            r_acc <= w_mac_bus;
                            if (w_final) begin
                                r_out_data  <= w_mac_bus;
                                r_out_valid <= 1'b1;
                                r_out_last  <= 1'b1;
                            end
                        end else begin
                            r_out_data  <= w_res_bus;
                            r_out_valid <= 1'b1;
                            r_out_last  <= w_final;
                        end
                        if (w_final) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_hs && r_out_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_alu_stream.sv
// Scoreboard bench for vec_alu_stream: driver pushes expected beats from a plain
// arithmetic reference model, an independent monitor pops and compares on each handshake.
module tb_vec_alu_stream;

    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int L    = 4;
    localparam int LW   = 10;
    localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W-1));

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [LW-1:0]    burst_len;
    logic             in_valid;
    logic             in_ready;
    logic [W*L-1:0]   a_in;
    logic [W*L-1:0]   b_in;
    logic             out_valid;
    logic             out_ready;
    logic [W*L-1:0]   out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    vec_alu_stream #(.WIDTH(W), .FRAC(FRAC), .LANES(L), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .burst_len(burst_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    typedef struct {
        logic [W*L-1:0] data;
        logic           last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   hs_cyc   = -10;
    bit   mon_en      = 1'b1;
    bit   force_stall = 1'b0;
    bit   rand_bp     = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = force_stall ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        longint s;
        s = sub ? (longint'($signed(a)) - longint'($signed(b))) : (longint'($signed(a)) + longint'($signed(b)));
        return W'(clampv(s));
    endfunction

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = (p + (longint'(1) <<< (FRAC-1))) >>> FRAC;
        return W'(clampv(p));
    endfunction

    function automatic logic [W-1:0] rnd_elem();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = W'($urandom_range(0, 2047)) - W'(1024);
            1:       v = $urandom_range(0, 1) ? W'(16'h7F00 + $urandom_range(0, 255)) : W'(16'h8000 + $urandom_range(0, 255));
            default: v = W'($urandom());
        endcase
        return v;
    endfunction

    // Monitor: compares every handshaken output beat against the scoreboard head.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mon_en && !rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_beat: got data %h last %b want no beat (cycle %0d)", out_data, out_last, cyc);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", 64'(out_last), 64'(e.last));
            end
            if (out_last) hs_cyc = cyc;
        end
    end

    // Runs one burst; with use_const every lane gets ca/cb and every result beat must equal cexp.
    task automatic do_burst(input logic [1:0] m, input int len, input bit use_const,
                            input logic [W-1:0] ca, input logic [W-1:0] cb, input logic [W-1:0] cexp);
        longint         acc[L];
        logic [W-1:0]   av, bv, ev;
        logic [W*L-1:0] a_bus, b_bus, e_bus;
        exp_t           e;
        int             waitc;
        for (int k = 0; k < L; k++) acc[k] = 0;
        mode      = m;
        burst_len = LW'(len);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        mode      = 2'($urandom());
        burst_len = LW'($urandom());
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < L; k++) begin
                av = use_const ? ca : rnd_elem();
                bv = use_const ? cb : rnd_elem();
                case (m)
                    2'b00: ev = ref_add(av, bv, 1'b0);
                    2'b01: ev = ref_add(av, bv, 1'b1);
                    2'b10: ev = ref_mul(av, bv);
                    default: begin
                        acc[k] = clampv(acc[k] + longint'($signed(ref_mul(av, bv))));
                        ev     = W'(acc[k]);
                    end
                endcase
                if (use_const) ev = cexp;
                a_bus[W*k +: W] = av;
                b_bus[W*k +: W] = bv;
                e_bus[W*k +: W] = ev;
            end
            a_in     = a_bus;
            b_in     = b_bus;
            in_valid = 1'b1;
            waitc    = 0;
            do begin
                @(negedge clk);
                waitc++;
            end while (!in_ready && waitc < 200);
            if (!in_ready) begin
                check("in_ready_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            if (m != 2'b11 || i == len - 1) begin
                e.data = e_bus;
                e.last = (i == len - 1);
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        a_in     = {$urandom(), $urandom()};
        b_in     = {$urandom(), $urandom()};
        waitc    = 0;
        while (!done && waitc < 500) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check("done_seen", 64'(done), 64'd1);
        if (done) begin
            check("done_latency", 64'(cyc), 64'(hs_cyc + 1));
            check("busy_low_at_done", 64'(busy), 64'd0);
            check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
            @(posedge clk);
            #1;
            check("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] held;
        int          wc;
        int          acc_cnt;
        bit          seen;
        rst = 1'b1; start = 1'b0; mode = '0; burst_len = '0;
        in_valid = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_burst(2'b00, 2, 1'b1, 16'h0180, 16'h0200, 16'h0380);
        do_burst(2'b00, 1, 1'b1, 16'h7000, 16'h7000, 16'h7FFF);
        do_burst(2'b01, 1, 1'b1, 16'h8000, 16'h0001, 16'h8000);
        do_burst(2'b10, 1, 1'b1, 16'h7F00, 16'h0200, 16'h7FFF);
        do_burst(2'b10, 1, 1'b1, 16'h0180, 16'h0200, 16'h0300);
        do_burst(2'b10, 1, 1'b1, 16'h0001, 16'h0080, 16'h0001);
        do_burst(2'b10, 1, 1'b1, 16'hFFFF, 16'h0080, 16'h0000);
        do_burst(2'b11, 3, 1'b1, 16'h0100, 16'h0200, 16'h0600);

        // Zero-length burst: done next cycle, nothing on the output.
        mode = 2'b00; burst_len = '0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("zero_len_done", 64'(done), 64'd1);
        check("zero_len_busy", 64'(busy), 64'd0);
        check("zero_len_no_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("zero_len_done_pulse", 64'(done), 64'd0);
        check("zero_len_no_valid2", 64'(out_valid), 64'd0);

        // Backpressure mid-burst, with an ignored start while busy.
        rand_bp = 1'b0;
        fork
            do_burst(2'b00, 8, 1'b0, 16'h0, 16'h0, 16'h0);
            begin
                wc = 0;
                while (!out_valid && wc < 100) begin
                    @(negedge clk);
                    wc++;
                end
                repeat (2) @(posedge clk);
                #1;
                force_stall = 1'b1;
                @(negedge clk);
                held = out_data;
                check("bp_valid_first", 64'(out_valid), 64'd1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 1) begin
                        start = 1'b1; mode = 2'b11; burst_len = LW'(1);
                    end
                    if (i == 2) start = 1'b0;
                    check("bp_valid_held", 64'(out_valid), 64'd1);
                    check("bp_data_held", out_data, held);
                    check("bp_in_ready_low", 64'(in_ready), 64'd0);
                end
                force_stall = 1'b0;
            end
        join

        // Randomized bursts under random output backpressure.
        rand_bp = 1'b1;
        for (int n = 0; n < 25; n++) begin
            do_burst(2'($urandom_range(0, 3)), $urandom_range(1, 12), 1'b0, 16'h0, 16'h0, 16'h0);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #1;

        // Reset after 3 of 8 beats: everything clears, no done, then a clean burst.
        mon_en = 1'b0;
        mode = 2'b00; burst_len = LW'(8); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b1;
        a_in = {$urandom(), $urandom()};
        b_in = {$urandom(), $urandom()};
        acc_cnt = 0;
        wc = 0;
        while (acc_cnt < 3 && wc < 100) begin
            @(negedge clk);
            if (in_ready) acc_cnt++;
            @(posedge clk);
            #1;
            wc++;
        end
        check("rst_mid_beats_taken", 64'(acc_cnt), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_out_last", 64'(out_last), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        check("rst_mid_out_data", out_data, 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("rst_mid_no_done", 64'(seen), 64'd0);
        mon_en = 1'b1;
        do_burst(2'b01, 4, 1'b0, 16'h0, 16'h0, 16'h0);
        do_burst(2'b11, 5, 1'b0, 16'h0, 16'h0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_alu_stream.md
Name: vec_alu_stream

Overview:
- Next-generation fixed-point vector engine for the simple adder accelerator.
- Processes LANES signed Q(WIDTH-FRAC).FRAC element pairs per beat over a valid/ready stream instead of flat MAX_N buses.
- Runtime-selectable add / sub / mul / mac modes with rounding and saturation; mac mode reduces a burst to one per-lane accumulated beat.
- Sits between the host DMA input stream and the result write-back stream.

Parameters:
WIDTH, 16, element width in bits (signed two's complement)
FRAC, 8, fractional bits; 1 <= FRAC < WIDTH
LANES, 4, elements processed per beat
LEN_W, 10, width of burst_len (beats per burst)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; launches a burst when idle
mode  in  2  00 add, 01 sub (a-b), 10 mul, 11 mac; sampled on start
burst_len  in  LEN_W  beats in burst; sampled on start
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
a_in  in  WIDTH*LANES  lane k at [WIDTH*k +: WIDTH]
b_in  in  WIDTH*LANES  same packing as a_in
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  WIDTH*LANES  result lanes, same packing
out_last  out  1  high with final result beat of burst
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset: synchronous active-high on clk; state IDLE. in_ready, out_valid, out_last, busy, done = 0; out_data = 0; beat counter and all accumulators = 0. Reset mid-burst aborts immediately with no done pulse and discards partial results.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start: latch mode and burst_len, clear counter and accumulators, busy=1 next cycle.
  - start with burst_len==0: go straight to IDLE, done pulses next cycle, no beats.
  - RUN -> DRAIN when the final input beat is accepted.
  - DRAIN -> IDLE when the final output beat is handshaken; done pulses 1 cycle after that handshake; busy falls with done.
  - start outside IDLE is ignored; latched mode and burst_len are unaffected.
- in_ready = (state==RUN) && (beats_accepted < burst_len) && (!out_valid || out_ready). This is combinational from out_ready and allows full throughput of 1 beat/cycle.
- Latency add/sub/mul: result is registered in out_data, out_valid the cycle after input acceptance. out_data and out_valid hold while out_valid && !out_ready.
- mac mode: each accepted beat updates acc[k] = sat(acc[k] + mulres[k]). No out_valid until the final beat; 1 cycle after it, out_data = acc, out_valid=1, out_last=1.
- out_last is high on the burst's final result beat only (every mode).
- Arithmetic, per lane, all signed:
  - Saturation range is [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - add/sub: compute in WIDTH+1 bits, then saturate.
  - mul: 2*WIDTH-bit product, add 2^(FRAC-1) (round half up), arithmetic shift right by FRAC, then saturate.
  - mac: uses the mul result above; saturating add into the WIDTH-bit accumulator.
- Counter is LEN_W bits and never wraps: maximum burst is 2^LEN_W-1 beats.
- Simultaneous final output handshake and new start: start is ignored (state is not IDLE).

Test Plan:
- Add, LANES=4, burst_len=2, all lanes a=0x0180, b=0x0200 -> out_data every lane 0x0380 on both beats; out_last on beat 2; done 1 cycle after second handshake.
- Saturation: add 0x7000+0x7000 -> 0x7FFF; sub 0x8000-0x0001 -> 0x8000; mul 0x7F00*0x0200 -> 0x7FFF.
- Mul rounding: 0x0180*0x0200 -> 0x0300; 0x0001*0x0080 -> 0x0001; 0xFFFF*0x0080 -> 0x0000.
- Mac: burst_len=3, each beat a=0x0100, b=0x0200 -> no output until final beat, then single beat with every lane 0x0600, out_last=1.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> in_ready=0, out_data/out_valid held, no beat lost or duplicated; burst_len=0 start -> done pulse next cycle with no out_valid.
- Reset mid-burst after 3 of 8 beats -> all outputs 0 next cycle, no done; new start runs a clean burst.
